// File: rtl/macnet_pkg.sv
// Shared types and helpers for the MAC-side datapath blocks (SRAM geometry, ReLU FSM states, header packing).
package macnet_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 12;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    DRAIN1,
    DRAIN2,
    HEADER
  } relu_state_t;

  // Matrix header word as the MAC reads it at address 0.
  function automatic logic [31:0] pack_header(input logic [15:0] rows, input logic [15:0] cols);
    return {rows, cols};
  endfunction

endpackage

// File: rtl/relu_writeback_if.sv
// Start handshake, status and both SRAM ports of the ReLU writeback stage.
interface relu_writeback_if
  import macnet_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              relu_valid;
  logic              relu_ready;
  logic [15:0]       num_rows;
  logic [15:0]       num_cols;
  logic              relu_done;
  logic              relu_error;
  logic [ADDR_W-1:0] nonzero_count;
  logic [ADDR_W-1:0] sram_result_read_address;
  logic [DATA_W-1:0] sram_result_read_data;
  logic              sram_input_write_enable;
  logic [ADDR_W-1:0] sram_input_write_address;
  logic [DATA_W-1:0] sram_input_write_data;

  modport slave (
    input  relu_valid, num_rows, num_cols, sram_result_read_data,
    output relu_ready, relu_done, relu_error, nonzero_count,
           sram_result_read_address, sram_input_write_enable,
           sram_input_write_address, sram_input_write_data
  );

  modport master (
    output relu_valid, num_rows, num_cols, sram_result_read_data,
    input  relu_ready, relu_done, relu_error, nonzero_count,
           sram_result_read_address, sram_input_write_enable,
           sram_input_write_address, sram_input_write_data
  );

endinterface

// File: rtl/relu_shift_unit.sv
// Combinational ReLU followed by an arithmetic right shift; shared by the activation stages.
module relu_shift_unit
  import macnet_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int OUT_SHIFT = 0
) (
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    if (!x[DATA_W-1]) y = $signed(x) >>> OUT_SHIFT;
  end

endmodule

// File: rtl/relu_writeback.sv
// Streams a finished product out of result SRAM through ReLU/shift into input SRAM, header last.
// Accept-to-done is N+3 cycles at one element per cycle, no stalls; relu_ready is low for the whole job.
module relu_writeback
  import macnet_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int OUT_SHIFT = 0
) (
  input logic             clk,
  input logic             reset,
  relu_writeback_if.slave bus
);

  localparam logic [31:0] MAX_N = 32'((1 << ADDR_W) - 1);

  relu_state_t       state_q, state_d;
  logic [31:0]       n_full;
  logic              accept, too_big, start, last_rd;
  logic [15:0]       rows_q, cols_q, hdr_rows, hdr_cols;
  logic [ADDR_W-1:0] last_addr_q, rd_addr_q, wr_addr_q, nz_q;
  logic              rd_vld_q, err_q, wr_en_q;
  logic [DATA_W-1:0] wr_data_q, relu_y;

  assign n_full  = 32'(bus.num_rows) * 32'(bus.num_cols);
  assign accept  = bus.relu_valid && (state_q == IDLE);
  assign too_big = (n_full > MAX_N);
  assign start   = accept && !too_big;
  assign last_rd = (rd_addr_q == last_addr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (n_full == 32'd0) ? HEADER : STREAM;
      STREAM:  if (last_rd) state_d = DRAIN1;
      DRAIN1:  state_d = DRAIN2;
      DRAIN2:  state_d = HEADER;
      HEADER:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.relu_ready = (state_q == IDLE);
    bus.relu_done  = (state_q == HEADER);
  end

  relu_shift_unit #(
    .DATA_W   (DATA_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_shift (
    .x(bus.sram_result_read_data),
    .y(relu_y)
  );

  // An empty matrix heads straight to HEADER from IDLE, before rows/cols are latched.
  assign hdr_rows = (state_q == IDLE) ? bus.num_rows : rows_q;
  assign hdr_cols = (state_q == IDLE) ? bus.num_cols : cols_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_q      <= '0;
      cols_q      <= '0;
      last_addr_q <= '0;
      rd_addr_q   <= '0;
      rd_vld_q    <= 1'b0;
      err_q       <= 1'b0;
      nz_q        <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      err_q    <= accept && too_big;
      rd_vld_q <= (state_q == STREAM);

      if (start) begin
        rows_q      <= bus.num_rows;
        cols_q      <= bus.num_cols;
        last_addr_q <= ADDR_W'(n_full - 32'd1);
        rd_addr_q   <= '0;
      end else if (state_q == STREAM && !last_rd) begin
        rd_addr_q <= rd_addr_q + ADDR_W'(1);
      end

      if (accept)
        nz_q <= '0;
      else if (rd_vld_q && relu_y != '0 && nz_q != '1)
        nz_q <= nz_q + ADDR_W'(1);

      // The write address always rests at 0 between jobs (header or reset), so elements start at 1.
      if (state_d == HEADER) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= '0;
        wr_data_q <= DATA_W'(pack_header(hdr_rows, hdr_cols));
      end else if (rd_vld_q) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= wr_addr_q + ADDR_W'(1);
        wr_data_q <= relu_y;
      end else begin
        wr_en_q <= 1'b0;
      end
    end
  end

  assign bus.relu_error               = err_q;
  assign bus.nonzero_count            = nz_q;
  assign bus.sram_result_read_address = rd_addr_q;
  assign bus.sram_input_write_enable  = wr_en_q;
  assign bus.sram_input_write_address = wr_addr_q;
  assign bus.sram_input_write_data    = wr_data_q;

endmodule

// File: tb/tb_relu_writeback.sv
// Bench for relu_writeback: table-driven jobs plus hand sequences, writes checked against a queue scoreboard.
module tb_relu_writeback;
  import macnet_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  relu_writeback_if #(.DATA_W(32), .ADDR_W(12)) b0 ();
  relu_writeback_if #(.DATA_W(32), .ADDR_W(12)) b2 ();

  relu_writeback #(.DATA_W(32), .ADDR_W(12), .OUT_SHIFT(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  relu_writeback #(.DATA_W(32), .ADDR_W(12), .OUT_SHIFT(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));

  logic [31:0] mem0 [0:4095];
  logic [31:0] mem2 [0:4095];
  always @(posedge clk) b0.sram_result_read_data <= mem0[b0.sram_result_read_address];
  always @(posedge clk) b2.sram_result_read_data <= mem2[b2.sram_result_read_address];

  typedef struct { logic [11:0] addr; logic [31:0] data; } wr_t;
  typedef struct {
    logic [15:0]      rows;
    logic [15:0]      cols;
    logic [7:0][31:0] din;   // element 0 is the rightmost word
    logic [7:0][31:0] dout;
    int               nz;
  } vec_t;

  wr_t  q0[$];
  wr_t  q2[$];
  vec_t tbl[4];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon0
    wr_t e;
    if (!reset && b0.sram_input_write_enable) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL dut0_unexpected_write: got addr %0h data %0h expected no write",
                 b0.sram_input_write_address, b0.sram_input_write_data);
      end else begin
        e = q0.pop_front();
        chk("dut0_write", {20'h0, b0.sram_input_write_address, b0.sram_input_write_data},
            {20'h0, e.addr, e.data});
      end
    end
  end

  always @(negedge clk) begin : mon2
    wr_t e;
    if (!reset && b2.sram_input_write_enable) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL dut2_unexpected_write: got addr %0h data %0h expected no write",
                 b2.sram_input_write_address, b2.sram_input_write_data);
      end else begin
        e = q2.pop_front();
        chk("dut2_write", {20'h0, b2.sram_input_write_address, b2.sram_input_write_data},
            {20'h0, e.addr, e.data});
      end
    end
  end

  task automatic push0(input logic [11:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a; e.data = d;
    q0.push_back(e);
  endtask

  task automatic push2(input logic [11:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a; e.data = d;
    q2.push_back(e);
  endtask

  task automatic run_job0(input vec_t v, input string tag);
    int n = int'(v.rows) * int'(v.cols);
    int got = -1;
    int k = 1;
    for (int i = 0; i < n; i++) begin
      mem0[i] = v.din[i];
      push0(12'(i + 1), v.dout[i]);
    end
    push0(12'h0, {v.rows, v.cols});
    @(posedge clk); #1;
    b0.relu_valid = 1'b1; b0.num_rows = v.rows; b0.num_cols = v.cols;
    @(negedge clk);
    chk({tag, "_ready_at_accept"}, b0.relu_ready, 1);
    @(posedge clk); #1;
    b0.relu_valid = 1'b0; b0.num_rows = 16'hFFFF; b0.num_cols = 16'hFFFF;
    while (got < 0 && k <= n + 10) begin
      @(negedge clk);
      if (b0.relu_done) got = k;
      else begin
        @(posedge clk);
        k++;
      end
    end
    chk({tag, "_done_cycle"}, got, (n == 0) ? 1 : n + 3);
    chk({tag, "_ready_in_header"}, b0.relu_ready, 0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_ready_after"}, b0.relu_ready, 1);
    chk({tag, "_done_pulse"}, b0.relu_done, 0);
    chk({tag, "_nonzero"}, b0.nonzero_count, v.nz);
    chk({tag, "_all_writes"}, q0.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    vec_t v;
    int acc[$];
    int dn[$];

    b0.relu_valid = 1'b0; b0.num_rows = '0; b0.num_cols = '0;
    b2.relu_valid = 1'b0; b2.num_rows = '0; b2.num_cols = '0;
    for (int i = 0; i < 4096; i++) begin
      mem0[i] = '0;
      mem2[i] = '0;
    end

    tbl[0].rows = 16'd2; tbl[0].cols = 16'd2; tbl[0].nz = 2;
    tbl[0].din  = {128'h0, 32'h7FFFFFFF, 32'h0, 32'hFFFFFFFD, 32'd5};
    tbl[0].dout = {128'h0, 32'h7FFFFFFF, 32'h0, 32'h0,        32'd5};
    tbl[1].rows = 16'd0; tbl[1].cols = 16'd5; tbl[1].nz = 0;
    tbl[1].din  = '0;
    tbl[1].dout = '0;
    tbl[2].rows = 16'd2; tbl[2].cols = 16'd3; tbl[2].nz = 3;
    tbl[2].din  = {64'h0, 32'h0, 32'h40000000, 32'd100, 32'hFFFFFFFF, 32'h80000000, 32'd1};
    tbl[2].dout = {64'h0, 32'h0, 32'h40000000, 32'd100, 32'h0,        32'h0,        32'd1};
    tbl[3].rows = 16'd3; tbl[3].cols = 16'd1; tbl[3].nz = 3;
    tbl[3].din  = {160'h0, 32'd9, 32'd8, 32'd7};
    tbl[3].dout = {160'h0, 32'd9, 32'd8, 32'd7};

    // Reset state, sampled while reset is still asserted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", b0.relu_ready, 1);
    chk("rst_done_err", {b0.relu_done, b0.relu_error}, 0);
    chk("rst_write_enable", b0.sram_input_write_enable, 0);
    chk("rst_addresses", {b0.sram_result_read_address, b0.sram_input_write_address}, 0);
    chk("rst_write_data", b0.sram_input_write_data, 0);
    chk("rst_nonzero", b0.nonzero_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 4; i++) run_job0(tbl[i], $sformatf("vec%0d", i));

    // Oversized job: 64*64 = 4096 exceeds the 12-bit address range.
    @(posedge clk); #1;
    b0.relu_valid = 1'b1; b0.num_rows = 16'd64; b0.num_cols = 16'd64;
    @(posedge clk); #1;
    b0.relu_valid = 1'b0;
    @(negedge clk);
    chk("err_pulse", b0.relu_error, 1);
    chk("err_ready_c1", b0.relu_ready, 1);
    chk("err_nonzero_cleared", b0.nonzero_count, 0);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("err_after_c%0d", j + 2), {b0.relu_error, b0.relu_ready}, 2'b01);
    end

    // Reset mid-STREAM of a 4x4 job; addr1..4 are written in cycles 3..6.
    for (int i = 0; i < 16; i++) begin
      mem0[i] = 32'(i + 1);
      push0(12'(i + 1), 32'(i + 1));
    end
    push0(12'h0, 32'h00040004);
    @(posedge clk); #1;
    b0.relu_valid = 1'b1; b0.num_rows = 16'd4; b0.num_cols = 16'd4;
    @(posedge clk); #1;
    b0.relu_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_write_enable", b0.sram_input_write_enable, 0);
    chk("midrst_ready", b0.relu_ready, 1);
    chk("midrst_done", b0.relu_done, 0);
    chk("midrst_writes_before", q0.size(), 13);
    q0.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_read_address", b0.sram_result_read_address, 0);
    v.rows = 16'd1; v.cols = 16'd1; v.nz = 0;
    v.din = {224'h0, 32'hFFFFFFFF};
    v.dout = '0;
    run_job0(v, "after_rst");

    // Back-to-back 2x3 jobs with relu_valid held high throughout.
    mem0[0] = 32'd3; mem0[1] = 32'hFFFFFF00; mem0[2] = 32'd9;
    mem0[3] = 32'd0; mem0[4] = 32'h12345678; mem0[5] = 32'h80000001;
    for (int r = 0; r < 2; r++) begin
      push0(12'd1, 32'd3); push0(12'd2, 32'd0); push0(12'd3, 32'd9);
      push0(12'd4, 32'd0); push0(12'd5, 32'h12345678); push0(12'd6, 32'd0);
      push0(12'd0, 32'h00020003);
    end
    @(posedge clk); #1;
    b0.relu_valid = 1'b1; b0.num_rows = 16'd2; b0.num_cols = 16'd3;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (b0.relu_valid && b0.relu_ready) acc.push_back(k);
      if (b0.relu_done) dn.push_back(k);
      @(posedge clk); #1;
      if (acc.size() == 2) b0.relu_valid = 1'b0;
    end
    chk("b2b_accepts", acc.size(), 2);
    chk("b2b_dones", dn.size(), 2);
    if (acc.size() == 2 && dn.size() == 2) begin
      chk("b2b_first_done", dn[0], 9);
      chk("b2b_second_accept", acc[1], 10);
      chk("b2b_second_done", dn[1], 19);
    end
    chk("b2b_all_writes", q0.size(), 0);
    chk("b2b_nonzero", b0.nonzero_count, 3);

    // OUT_SHIFT=2 instance: 1x3 {16,-16,7} -> {4,0,1}, writes in cycles 3..5, header in 6.
    mem2[0] = 32'd16; mem2[1] = 32'hFFFFFFF0; mem2[2] = 32'd7;
    push2(12'd1, 32'd4); push2(12'd2, 32'd0); push2(12'd3, 32'd1); push2(12'd0, 32'h00010003);
    @(posedge clk); #1;
    b2.relu_valid = 1'b1; b2.num_rows = 16'd1; b2.num_cols = 16'd3;
    @(posedge clk); #1;
    b2.relu_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("shift_we_c%0d", k), b2.sram_input_write_enable, (k >= 3 && k <= 6));
      if (k == 6) chk("shift_done_c6", b2.relu_done, 1);
      @(posedge clk);
    end
    @(negedge clk);
    chk("shift_nonzero", b2.nonzero_count, 2);
    chk("shift_all_writes", q2.size(), 0);

    // Small values shift to zero and must not count as nonzero.
    mem2[0] = 32'd3; mem2[1] = 32'h7FFFFFFF;
    push2(12'd1, 32'd0); push2(12'd2, 32'h1FFFFFFF); push2(12'd0, 32'h00010002);
    @(posedge clk); #1;
    b2.relu_valid = 1'b1; b2.num_rows = 16'd1; b2.num_cols = 16'd2;
    @(posedge clk); #1;
    b2.relu_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5) chk("shift2_done_c5", b2.relu_done, 1);
      @(posedge clk);
    end
    @(negedge clk);
    chk("shift2_nonzero", b2.nonzero_count, 1);
    chk("shift2_all_writes", q2.size(), 0);
    chk("final_queue0", q0.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
